oam_dma_ctrl: RTL and testbench

OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

---
 rtl/oam_dma_ctrl.sv | 154 +++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl -- OAM DMA controller with OAM port arbitration.
//
// A CPU write to 0xFF46 latches the source page and copies DMA_LEN bytes
// from {base, idx} into OAM 0xFE00+idx, one byte every two cycles
// (RD then WR). While the copy runs, the DMA engine owns the OAM port.
// When the DMA engine is idle, the PPU owns the port while it is busy, and
// otherwise the CPU can access 0xFE00-0xFE9F.
//
// Configuration macro: OAM_DMA_HRAM_ONLY_EN
//   defined   -> cpu_bus_block is raised while a transfer runs and cpu_a is
//                outside HRAM (0xFF80-0xFFFE)
//   undefined -> cpu_bus_block is tied low
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   cpu_a/din/wr/dout   CPU address, write data, write strobe, read data
//   ppu_busy            PPU is in mode 2 or 3
//   ppu_oam_a/oam_dout  PPU OAM address and returned data
//   src_a/rd/dout       DMA source bus (data valid one cycle after src_rd)
//   oam_a/din/wr/dout   OAM RAM port (read data combinational)
//   dma_active          transfer in progress
//   cpu_bus_block       CPU must stall its non-HRAM access
module oam_dma_ctrl #(
  parameter int DMA_LEN = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_dout,
  input  logic        ppu_busy,
  input  logic [15:0] ppu_oam_a,
  output logic [7:0]  ppu_oam_dout,
  output logic [15:0] src_a,
  output logic        src_rd,
  input  logic [7:0]  src_dout,
  output logic [15:0] oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_wr,
  input  logic [7:0]  oam_dout,
  output logic        dma_active,
  output logic        cpu_bus_block
);

  typedef enum logic [1:0] {IDLE, START, RD, WR} state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t      state_q, state_d;
  logic [7:0]  dma_q, dma_d;
  logic [7:0]  idx_q, idx_d;

  logic        dma_reg_wr;
  logic        cpu_oam_sel;
  logic [7:0]  base;

  assign dma_reg_wr  = cpu_wr && (cpu_a == 16'hFF46);
  assign cpu_oam_sel = (cpu_a >= 16'hFE00) && (cpu_a <= 16'hFE9F);
  // Pages 0xE0-0xFF are echo RAM; fold them back onto 0xC0-0xDF.
  assign base        = (dma_q >= 8'hE0) ? (dma_q - 8'h20) : dma_q;
  assign dma_active  = (state_q != IDLE);

`ifdef OAM_DMA_HRAM_ONLY_EN
  assign cpu_bus_block = dma_active && !((cpu_a >= 16'hFF80) && (cpu_a <= 16'hFFFE));
`else
  assign cpu_bus_block = 1'b0;
`endif

  // State, page register and byte index; reset wins over a register write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dma_q   <= 8'h00;
      idx_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      dma_q   <= dma_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state sequencing; a write to 0xFF46 restarts from any state.
  always_comb begin
    state_d = state_q;
    dma_d   = dma_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  state_d = IDLE;
      START: state_d = RD;
      RD:    state_d = WR;
      WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          state_d = RD;
          idx_d   = idx_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The WR byte of this cycle still lands because outputs come from state_q.
    if (dma_reg_wr) begin
      dma_d   = cpu_din;
      state_d = START;
      idx_d   = 8'h00;
    end else begin
      dma_d = dma_d;
    end
  end

  // OAM port arbitration (DMA > PPU > CPU) and read-data steering.
  always_comb begin
    src_rd       = 1'b0;
    src_a        = 16'h0000;
    oam_a        = 16'hFFFF;
    oam_wr       = 1'b0;
    oam_din      = 8'h00;
    ppu_oam_dout = 8'hFF;
    cpu_dout     = 8'hFF;
    case (state_q)
      RD: begin
        src_rd = 1'b1;
        src_a  = {base, idx_q};
      end
      WR: begin
        oam_wr  = 1'b1;
        oam_a   = {8'hFE, idx_q};
        oam_din = src_dout;
      end
      IDLE: begin
        if (ppu_busy) begin
          oam_a        = ppu_oam_a;
          ppu_oam_dout = oam_dout;
        end else if (cpu_oam_sel) begin
          oam_a    = cpu_a;
          oam_wr   = cpu_wr;
          oam_din  = cpu_din;
          cpu_dout = oam_dout;
        end else begin
          oam_a = 16'hFFFF;
        end
      end
      // START: the port is owned by DMA but idle.
      default: oam_a = 16'hFFFF;
    endcase
    if (cpu_a == 16'hFF46) begin
      cpu_dout = dma_q;
    end else begin
      cpu_dout = cpu_dout;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected OAM writes and source reads
// are queued by the stimulus; a negedge monitor pops and compares them.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_din;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic        ppu_busy;
  logic [15:0] ppu_oam_a;
  logic [7:0]  ppu_oam_dout;
  logic [15:0] src_a;
  logic        src_rd;
  logic [7:0]  src_dout;
  logic [15:0] oam_a;
  logic [7:0]  oam_din;
  logic        oam_wr;
  logic [7:0]  oam_dout;
  logic        dma_active;
  logic        cpu_bus_block;

  logic [7:0]  mem [0:255];
  logic        mem_clr;
  logic [23:0] oam_q [$];
  logic [15:0] src_q [$];
  logic [23:0] oam_exp;
  logic [15:0] src_exp;
  int          n_vec;
  int          n_err;
  int          n;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .ppu_busy(ppu_busy), .ppu_oam_a(ppu_oam_a), .ppu_oam_dout(ppu_oam_dout),
    .src_a(src_a), .src_rd(src_rd), .src_dout(src_dout),
    .oam_a(oam_a), .oam_din(oam_din), .oam_wr(oam_wr), .oam_dout(oam_dout),
    .dma_active(dma_active), .cpu_bus_block(cpu_bus_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory returns the low address byte one cycle after src_rd.
  always @(posedge clk) begin
    if (src_rd === 1'b1) src_dout <= src_a[7:0];
  end

  // OAM RAM model with combinational read.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hAA;
    end else if (oam_wr === 1'b1 && oam_a[15:8] == 8'hFE) begin
      mem[oam_a[7:0]] <= oam_din;
    end
  end
  assign oam_dout = (oam_a[15:8] == 8'hFE) ? mem[oam_a[7:0]] : 8'hFF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every OAM write and source read must match the queue head.
  always @(negedge clk) begin
    if (oam_wr === 1'b1) begin
      if (oam_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL oam_wr_unexpected: got a=%h d=%h expected no write", oam_a, oam_din);
      end else begin
        oam_exp = oam_q.pop_front();
        chk("oam_wr", {8'h00, oam_a, oam_din}, {8'h00, oam_exp});
      end
    end
    if (src_rd === 1'b1) begin
      if (src_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL src_rd_unexpected: got a=%h expected no read", src_a);
      end else begin
        src_exp = src_q.pop_front();
        chk("src_rd", {16'h0000, src_a}, {16'h0000, src_exp});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_a = a; cpu_din = d; cpu_wr = 1'b1;
    cyc();
    cpu_wr = 1'b0; cpu_a = 16'h0000; cpu_din = 8'h00;
  endtask

  task automatic push_xfer(input logic [7:0] hi, input int nrd, input int nwr);
    for (int i = 0; i < nrd; i++) src_q.push_back({hi, 8'(i)});
    for (int i = 0; i < nwr; i++) oam_q.push_back({8'hFE, 8'(i), 8'(i)});
  endtask

  task automatic count_active(input string name);
    n = 0;
    while (dma_active === 1'b1 && n < 1000) begin
      n++;
      cyc();
    end
    chk(name, n, 321);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; cpu_a = 16'h0000; cpu_din = 8'h00; cpu_wr = 1'b0;
    ppu_busy = 1'b0; ppu_oam_a = 16'h0000; mem_clr = 1'b1; src_dout = 8'h00;
    repeat (3) cyc();
    mem_clr = 1'b0; rst = 1'b0;

    // Reset state
    chk("rst_dma_active", dma_active, 0);
    chk("rst_src_rd", src_rd, 0);
    chk("rst_src_a", src_a, 32'h0000);
    chk("rst_oam_wr", oam_wr, 0);
    chk("rst_oam_a", oam_a, 32'hFFFF);
    chk("rst_oam_din", oam_din, 0);
    chk("rst_cpu_bus_block", cpu_bus_block, 0);
    chk("rst_cpu_dout", cpu_dout, 32'hFF);
    chk("rst_ppu_oam_dout", ppu_oam_dout, 32'hFF);
    cpu_a = 16'hFF46; #1;
    chk("rst_dma_reg", cpu_dout, 32'h00);
    cpu_a = 16'h0000;

    // Full transfer from page 0xC1
    push_xfer(8'hC1, 160, 160);
    cpu_write(16'hFF46, 8'hC1);
    count_active("c1_active_len");
    cyc();
    cpu_a = 16'hFE00; #1; chk("c1_rd_fe00", cpu_dout, 32'h00);
    cpu_a = 16'hFE50; #1; chk("c1_rd_fe50", cpu_dout, 32'h50);
    cpu_a = 16'hFE9F; #1; chk("c1_rd_fe9f", cpu_dout, 32'h9F);
    cpu_a = 16'hFEA0; #1; chk("rd_fea0", cpu_dout, 32'hFF);
    chk("fea0_oam_a", oam_a, 32'hFFFF);
    cpu_a = 16'h0000;

    // Echo page 0xFE maps to 0xDE; blocked reads while active
    push_xfer(8'hDE, 160, 160);
    cpu_write(16'hFF46, 8'hFE);
    cpu_a = 16'hFE05; #1; chk("dma_cpu_oam_rd", cpu_dout, 32'hFF);
    ppu_busy = 1'b1; ppu_oam_a = 16'hFE05; #1;
    chk("dma_ppu_oam_rd", ppu_oam_dout, 32'hFF);
    ppu_busy = 1'b0;
    cpu_a = 16'hFF46; #1; chk("fe_rd_ff46", cpu_dout, 32'hFE);
`ifdef OAM_DMA_HRAM_ONLY_EN
    cpu_a = 16'hC000; #1; chk("block_c000", cpu_bus_block, 1);
    cpu_a = 16'hFF90; #1; chk("block_ff90", cpu_bus_block, 0);
`else
    cpu_a = 16'hC000; #1; chk("block_c000", cpu_bus_block, 0);
    cpu_a = 16'hFF90; #1; chk("block_ff90", cpu_bus_block, 0);
`endif
    cpu_a = 16'h0000;
    count_active("fe_active_len");
    cyc();

    // Restart with 0x80 during the WR of idx 50
    push_xfer(8'hC1, 51, 51);
    push_xfer(8'h80, 160, 160);
    cpu_write(16'hFF46, 8'hC1);
    n = 0;
    while (!(oam_wr === 1'b1 && oam_a == 16'hFE32) && n < 400) begin
      n++;
      cyc();
    end
    chk("restart_found_idx50", (n < 400), 1);
    cpu_write(16'hFF46, 8'h80);
    count_active("restart_active_len");
    cyc();

    // PPU owns the port: CPU access dropped
    ppu_busy = 1'b1; ppu_oam_a = 16'hFE10; cpu_a = 16'hFE10; #1;
    chk("ppu_oam_a", oam_a, 32'hFE10);
    chk("ppu_oam_dout", ppu_oam_dout, 32'h10);
    chk("ppu_cpu_rd", cpu_dout, 32'hFF);
    cpu_write(16'hFE10, 8'h55);
    cpu_a = 16'hFE10; #1;
    chk("ppu_cpu_rd_after", cpu_dout, 32'hFF);
    chk("ppu_mem_unchanged", mem[8'h10], 32'h10);
    ppu_busy = 1'b0; #1;
    chk("cpu_rd_pre", cpu_dout, 32'h10);
    oam_q.push_back({16'hFE10, 8'h55});
    cpu_write(16'hFE10, 8'h55);
    cpu_a = 16'hFE10; #1;
    chk("cpu_rd_55", cpu_dout, 32'h55);
    cpu_a = 16'h0000;

    // Reset during RD of idx 80
    mem_clr = 1'b1; cyc(); mem_clr = 1'b0;
    push_xfer(8'hC1, 81, 80);
    cpu_write(16'hFF46, 8'hC1);
    n = 0;
    while (!(src_rd === 1'b1 && src_a == 16'hC150) && n < 400) begin
      n++;
      cyc();
    end
    chk("rst_found_idx80", (n < 400), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_dma_active", dma_active, 0);
    chk("midrst_oam_wr", oam_wr, 0);
    cpu_a = 16'hFF46; #1; chk("midrst_dma_reg", cpu_dout, 32'h00);
    cpu_a = 16'h0000;
    repeat (4) cyc();
    chk("midrst_mem_4f", mem[8'h4F], 32'h4F);
    chk("midrst_mem_50", mem[8'h50], 32'hAA);
    chk("midrst_mem_9f", mem[8'h9F], 32'hAA);

    // Reset beats a simultaneous 0xFF46 write
    rst = 1'b1;
    cpu_write(16'hFF46, 8'h33);
    rst = 1'b0;
    chk("rstprio_active", dma_active, 0);
    cpu_a = 16'hFF46; #1; chk("rstprio_dma_reg", cpu_dout, 32'h00);
    cpu_a = 16'h0000;
    cyc();
    chk("rstprio_still_idle", dma_active, 0);

    repeat (2) cyc();
    chk("oam_q_empty", oam_q.size(), 0);
    chk("src_q_empty", src_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
